am_search: RTL and testbench

Associative-memory search stage that sits directly downstream of the HV encoder in `top_system`. When started, it snapshots the encoded query hypervector and walks the AM rows from a CSR-programmed base address to a max address. For each row it computes the Hamming distance to the query with a chunked popcount and reports the index and distance of the closest row. Its `result_o` feeds the 5-bit class field of the CSR status register, and its `done_o` feeds the output-valid bit.

---
 rtl/am_search.sv | 179 +++++++++++++++++
 tb/tb_am_search.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/am_search.sv
// Associative-memory search: walks AM rows base..max, returns index/distance of nearest row to query.
// Latency: 1 + R*(NCHUNK+2) cycles from accepted start to done_o (R = rows in range).
// No backpressure: AM read data is assumed valid one cycle after am_ren_o; start_i while busy is dropped.
module am_search #(
  parameter int HV_LENGTH       = 2048,
  parameter int AM_ADDR_WIDTH   = 13,
  parameter int ROW_STRIDE_LOG2 = 8,
  parameter int CHUNK_WIDTH     = 256,
  parameter int CLASS_WIDTH     = 5
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [HV_LENGTH-1:0]           query_hv_i,
  input  logic [AM_ADDR_WIDTH-1:0]       base_addr_i,
  input  logic [AM_ADDR_WIDTH-1:0]       max_addr_i,
  output logic                           am_ren_o,
  output logic [AM_ADDR_WIDTH-1:0]       am_addr_o,
  input  logic [HV_LENGTH-1:0]           am_rdata_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [CLASS_WIDTH-1:0]         result_o,
  output logic [$clog2(HV_LENGTH+1)-1:0] distance_o
);

  localparam int NCHUNK  = HV_LENGTH / CHUNK_WIDTH;
  localparam int DIST_W  = $clog2(HV_LENGTH + 1);
  localparam int POP_W   = $clog2(CHUNK_WIDTH + 1);
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int ADDR_W1 = AM_ADDR_WIDTH + 1;

  localparam logic [AM_ADDR_WIDTH-1:0] ADDR_MASK = {AM_ADDR_WIDTH{1'b1}} << ROW_STRIDE_LOG2;
  localparam logic [ADDR_W1-1:0]       ROW_STEP  = ADDR_W1'(1) << ROW_STRIDE_LOG2;
  localparam logic [CNT_W-1:0]         LAST_CHUNK = CNT_W'(NCHUNK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_ACC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [HV_LENGTH-1:0]   query_q;
  logic [HV_LENGTH-1:0]   diff_q;
  logic [DIST_W-1:0]      acc_q;
  logic [CNT_W-1:0]       chunk_q;
  // One bit wider than the AM address so the walk can never wrap back to 0.
  logic [ADDR_W1-1:0]     addr_q;
  logic [AM_ADDR_WIDTH-1:0] max_q;
  logic [CLASS_WIDTH-1:0] row_q;
  logic [DIST_W-1:0]      best_dist_q, best_dist_d;
  logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [CLASS_WIDTH-1:0] result_q;
  logic [DIST_W-1:0]      distance_q;

  logic [AM_ADDR_WIDTH-1:0] base_m, max_m;
  logic                     empty_range;
  logic                     chunk_last;
  logic [DIST_W-1:0]        sum;
  logic [ADDR_W1-1:0]       addr_nxt;
  logic                     row_end;

  function automatic logic [POP_W-1:0] popcount(input logic [CHUNK_WIDTH-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

  assign base_m      = base_addr_i & ADDR_MASK;
  assign max_m       = max_addr_i & ADDR_MASK;
  assign empty_range = (base_m > max_m);
  assign chunk_last  = (chunk_q == LAST_CHUNK);
  // diff_q is shifted down each ACC cycle, so the current chunk always sits in the low bits.
  assign sum         = acc_q + DIST_W'(popcount(diff_q[CHUNK_WIDTH-1:0]));
  assign addr_nxt    = addr_q + ROW_STEP;
  assign row_end     = addr_nxt[AM_ADDR_WIDTH] || (addr_nxt > {1'b0, max_q});
  assign am_addr_o   = addr_q[AM_ADDR_WIDTH-1:0];
  assign result_o    = result_q;
  assign distance_o  = distance_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one READ/LATCH/ACC pass per row, zero rows go straight to DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = empty_range ? S_DONE : S_READ;
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_ACC;
      S_ACC:   if (chunk_last) state_d = row_end ? S_DONE : S_READ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state.
  always_comb begin
    busy_o   = (state_q != S_IDLE);
    am_ren_o = (state_q == S_READ);
    done_o   = (state_q == S_DONE);
  end

  // Best-row tracking: strict less-than keeps the lower index on ties.
  always_comb begin
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    if (state_q == S_IDLE && start_i) begin
      best_dist_d = DIST_W'(HV_LENGTH);
      best_idx_d  = '0;
    end else if (state_q == S_ACC && chunk_last && (sum < best_dist_q)) begin
      best_dist_d = sum;
      best_idx_d  = row_q;
    end
  end

  // Datapath: query snapshot, row walk, chunked accumulation and result capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      query_q     <= '0;
      diff_q      <= '0;
      acc_q       <= '0;
      chunk_q     <= '0;
      addr_q      <= '0;
      max_q       <= '0;
      row_q       <= '0;
      best_dist_q <= '0;
      best_idx_q  <= '0;
      result_q    <= '0;
      distance_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            query_q <= query_hv_i;
            addr_q  <= {1'b0, base_m};
            max_q   <= max_m;
            row_q   <= '0;
          end
        end
        S_LATCH: begin
          diff_q  <= am_rdata_i ^ query_q;
          acc_q   <= '0;
          chunk_q <= '0;
        end
        S_ACC: begin
          diff_q  <= diff_q >> CHUNK_WIDTH;
          acc_q   <= sum;
          chunk_q <= chunk_q + CNT_W'(1);
          if (chunk_last) begin
            addr_q <= addr_nxt;
            row_q  <= row_q + CLASS_WIDTH'(1);
          end
        end
        default: ;
      endcase
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
      // Results are captured on entry to DONE so they are valid alongside done_o.
      if (state_d == S_DONE && state_q != S_DONE) begin
        result_q   <= best_idx_d;
        distance_q <= best_dist_d;
      end
    end
  end

endmodule

// File: tb/tb_am_search.sv
// Directed bench for am_search: AM modelled as a 32-row array with 1-cycle read latency.
// Each search checks done latency, read strobes/addresses, result and distance.
// Control hazards: restart while busy, reset mid-search, fresh start after reset.
module tb_am_search;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2047:0] query;
  logic [12:0]   base_addr;
  logic [12:0]   max_addr;
  logic          am_ren;
  logic [12:0]   am_addr;
  logic [2047:0] am_rdata;
  logic          busy;
  logic          done;
  logic [4:0]    result;
  logic [11:0]   distance;

  logic [2047:0] am_mem [32];
  logic [12:0]   ren_log[$];

  int n_chk  = 0;
  int n_fail = 0;

  am_search dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .query_hv_i (query),
    .base_addr_i(base_addr),
    .max_addr_i (max_addr),
    .am_ren_o   (am_ren),
    .am_addr_o  (am_addr),
    .am_rdata_i (am_rdata),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .distance_o (distance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AM model: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (am_ren) begin
      ren_log.push_back(am_addr);
      am_rdata <= am_mem[am_addr[12:8]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flip n distinct bits (stride 97) starting at offset -> Hamming distance exactly n.
  function automatic logic [2047:0] flipn(input logic [2047:0] v, input int n, input int off);
    logic [2047:0] r;
    r = v;
    for (int i = 0; i < n; i++) r[off + i * 97] = ~r[off + i * 97];
    return r;
  endfunction

  task automatic start_search(input logic [12:0] b, input logic [12:0] m);
    @(negedge clk);
    ren_log.delete();
    base_addr = b;
    max_addr  = m;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns offset (cycles after accepting edge) of done_o; optional restart pulse at T+5.
  task automatic wait_done(input bit restart, output int lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_run", {31'd0, busy}, 32'd1);
      if (restart && n == 5) begin
        start     = 1'b1;
        base_addr = 13'h0000;
        max_addr  = 13'h1F00;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    lat = n;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reads(input int nrows, input logic [12:0] first);
    chk("ren_count", ren_log.size(), nrows);
    for (int i = 0; i < ren_log.size() && i < nrows; i++)
      chk("ren_addr", {19'd0, ren_log[i]}, {19'd0, first} + 32'(i) * 32'h100);
  endtask

  task automatic load_seven();
    for (int k = 1; k <= 7; k++) am_mem[k] = query ^ {64{32'hF0F0_F0F0}};
    am_mem[5] = flipn(query, 3, 1);
  endtask

  initial begin
    int lat;
    int nd;
    rst_n     = 1'b0;
    start     = 1'b0;
    query     = {64{32'h1234_5678}};
    base_addr = '0;
    max_addr  = '0;
    am_rdata  = '0;
    for (int k = 0; k < 32; k++) am_mem[k] = ~query;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ren", {31'd0, am_ren}, 32'd0);
    chk("rst_result", {27'd0, result}, 32'd0);
    chk("rst_distance", {20'd0, distance}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single row equal to the query.
    am_mem[1] = query;
    start_search(13'h0100, 13'h0100);
    wait_done(1'b0, lat);
    chk("single_lat", lat, 11);
    chk("single_result", {27'd0, result}, 0);
    chk("single_dist", {20'd0, distance}, 0);
    chk_reads(1, 13'h0100);

    // Seven rows, row 0x500 at distance 3.
    load_seven();
    start_search(13'h0100, 13'h0700);
    wait_done(1'b0, lat);
    chk("seven_lat", lat, 71);
    chk("seven_result", {27'd0, result}, 4);
    chk("seven_dist", {20'd0, distance}, 3);
    chk_reads(7, 13'h0100);

    // Empty range.
    start_search(13'h0300, 13'h0200);
    wait_done(1'b0, lat);
    chk("empty_lat", lat, 1);
    chk("empty_result", {27'd0, result}, 0);
    chk("empty_dist", {20'd0, distance}, 2048);
    chk("empty_reads", ren_log.size(), 0);

    // Top of address space, low bits of base/max must be masked off.
    am_mem[30] = flipn(query, 7, 2);
    am_mem[31] = flipn(query, 5, 4);
    am_mem[0]  = query;
    start_search(13'h1E37, 13'h1F55);
    wait_done(1'b0, lat);
    chk("top_lat", lat, 21);
    chk("top_result", {27'd0, result}, 1);
    chk("top_dist", {20'd0, distance}, 5);
    chk_reads(2, 13'h1E00);

    // Restart while busy is ignored.
    am_mem[1] = flipn(query, 2, 3);
    start_search(13'h0100, 13'h0100);
    wait_done(1'b1, lat);
    chk("restart_lat", lat, 11);
    chk("restart_result", {27'd0, result}, 0);
    chk("restart_dist", {20'd0, distance}, 2);
    chk_reads(1, 13'h0100);

    // Tie between index 1 and 3: lower index wins.
    am_mem[0] = flipn(query, 20, 0);
    am_mem[1] = flipn(query, 10, 5);
    am_mem[2] = flipn(query, 20, 6);
    am_mem[3] = flipn(query, 10, 7);
    am_mem[4] = flipn(query, 20, 8);
    start_search(13'h0000, 13'h0400);
    wait_done(1'b0, lat);
    chk("tie_lat", lat, 51);
    chk("tie_result", {27'd0, result}, 1);
    chk("tie_dist", {20'd0, distance}, 10);

    // Reset mid-search.
    load_seven();
    start_search(13'h0100, 13'h0700);
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ren", {31'd0, am_ren}, 32'd0);
    chk("midrst_result", {27'd0, result}, 0);
    chk("midrst_dist", {20'd0, distance}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midrst_no_done", nd, 0);

    // Fresh start after reset.
    start_search(13'h0100, 13'h0700);
    wait_done(1'b0, lat);
    chk("fresh_lat", lat, 71);
    chk("fresh_result", {27'd0, result}, 4);
    chk("fresh_dist", {20'd0, distance}, 3);
    chk_reads(7, 13'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
